serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 73 +++++++
 tb/tb_serial_subtractor.sv | 113 +++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned a - b - bin, LSB first, one full-subtractor cell
// start/busy/done handshake; diff/borrow registered and held between completions
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] d_sh;
  logic             bor;
  logic [CW-1:0]    cnt;
  logic             d, bor_nxt;
  logic [WIDTH-1:0] d_nxt;
  assign d       = a_sh[0] ^ b_sh[0] ^ bor;
  assign bor_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bor);
  assign d_nxt   = {d, d_sh};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        BUSY: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_nxt[WIDTH-1:1];
          bor  <= bor_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            diff   <= d_nxt;
            borrow <= bor_nxt;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            bor   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive checks of serial_subtractor (WIDTH=4)
module tb_serial_subtractor;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic       bin = 1'b0;
  logic       busy, done, borrow;
  logic [3:0] diff;
  logic [4:0] last = '0;
  int         checks = 0, errors = 0, n;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic bv_in);
    a = av; b = bv; bin = bv_in; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
  endtask

  task automatic issue(input logic [3:0] av, input logic [3:0] bv, input logic bv_in);
    @(negedge clk);
    drive(av, bv, bv_in);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      check("busy_while_running", busy, 1);
      check("held_result", {borrow, diff}, last);
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
  endtask

  task automatic finish_op(input string tag, input logic [4:0] exp, input int lat);
    wait_done(n);
    check({tag, "_latency"}, n, lat);
    check(tag, {borrow, diff}, exp);
    last = {borrow, diff};
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, borrow, diff}, 0);
    rst_n = 1'b1;
    // basic: 3 - 1 - 0
    issue(4'b0011, 4'b0001, 1'b0);
    finish_op("basic", 5'b0_0010, 4);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("diff_held", {borrow, diff}, 5'b0_0010);
    issue(4'b0001, 4'b0010, 1'b0); finish_op("underflow", 5'b1_1111, 4);
    issue(4'b1010, 4'b0101, 1'b1); finish_op("bin_sub", 5'b0_0100, 4);
    issue(4'b0000, 4'b1111, 1'b1); finish_op("zero_minus_max", 5'b1_0000, 4);
    issue(4'b1111, 4'b1111, 1'b1); finish_op("max_minus_max_bin", 5'b1_1111, 4);
    // back-to-back: start sampled in the done cycle
    drive(4'b1000, 4'b0001, 1'b0);
    finish_op("back_to_back", 5'b0_0111, 4);
    // start while busy is ignored
    issue(4'b0110, 4'b0011, 1'b0);
    @(negedge clk);
    a = 4'b0000; b = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op("ignore_busy", 5'b0_0011, 2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_second_done", {busy, done}, 0);
    end
    // asynchronous reset mid-operation
    issue(4'b0111, 4'b0010, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {busy, done, borrow, diff}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_done_after_reset", {busy, done}, 0);
    end
    issue(4'b1001, 4'b0100, 1'b1); finish_op("after_reset", 5'b0_0100, 4);
    // exhaustive against the modulo-32 model
    for (int i = 0; i < 512; i++) begin
      logic [3:0] av, bv;
      logic       cv;
      logic [4:0] exp;
      av = 4'(i >> 5); bv = 4'(i >> 1); cv = 1'(i);
      exp = 5'({1'b0, av} - {1'b0, bv} - {4'b0, cv});
      issue(av, bv, cv);
      finish_op("exhaustive", exp, 4);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
